// File: rtl/pad_pkg.sv
// Shared button bit positions and command codes used by the gamepad
// command queue and by anything that consumes its commands.
package pad_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_NONE   = 3'd0;
  localparam cmd_t CMD_UP     = 3'd1;
  localparam cmd_t CMD_DOWN   = 3'd2;
  localparam cmd_t CMD_LEFT   = 3'd3;
  localparam cmd_t CMD_RIGHT  = 3'd4;
  localparam cmd_t CMD_ACTION = 3'd5;
  localparam cmd_t CMD_MODE   = 3'd6;
  localparam cmd_t CMD_START  = 3'd7;

endpackage

// File: rtl/pad_cmd_queue_if.sv
// Command stream from the pad queue (master) to the world FSM (slave).
interface pad_cmd_queue_if;
  import pad_pkg::*;

  // A command transfers on every clock edge where cmd_valid & cmd_ready.
  // cmd_code is stable while cmd_valid is high and not yet accepted;
  // cmd_ready may be asserted freely and is ignored while cmd_valid is low.
  logic cmd_valid;
  cmd_t cmd_code;
  logic cmd_ready;

  modport master (output cmd_valid, output cmd_code, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_code, output cmd_ready);

endinterface

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO; head shows the oldest entry, or zero when empty.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    // The extra pointer bit separates full (bits differ) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pad_cmd_queue.sv
// Debounces gamepad buttons per VGA frame and queues move/action commands.
// Define PAD_AUTOREPEAT_EN to build direction auto-repeat.
module pad_cmd_queue
    import pad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 6,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              vga_vs,
    input  logic [11:0]       buttons,
    output logic [11:0]       held,
    pad_cmd_queue_if.master   cmd,
    output logic              overflow
);

    localparam logic [2:0] DEB = 3'(DEBOUNCE_FRAMES);

    logic       vs_q, tick, tick_d;
    logic [7:0] held_prev;
    logic [2:0] cnt [12];
    logic [7:0] press;
    logic [3:0] dir_ev;
    cmd_t       push_code;
    logic       push, pop, full, empty;

    assign tick = vs_q & ~vga_vs;

    always_ff @(posedge clock_50) begin
        if (reset) begin
            vs_q      <= 1'b0;
            tick_d    <= 1'b0;
            held      <= '0;
            held_prev <= '0;
            for (int i = 0; i < 12; i++) cnt[i] <= '0;
        end else begin
            vs_q   <= vga_vs;
            tick_d <= tick;
            if (tick) begin
                held_prev <= held[7:0];
                for (int i = 0; i < 12; i++) begin
                    if (buttons[i] != held[i]) begin
                        if (cnt[i] + 3'd1 == DEB) begin
                            held[i] <= ~held[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 3'd1;
                        end
                    end else begin
                        cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Buttons above start never produce commands, so only the low byte is edge-detected.
    assign press = held[7:0] & ~held_prev;

`ifdef PAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
    localparam logic [RW-1:0] R_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] R_WRAP  = RW'(REPEAT_DELAY + REPEAT_RATE);

    logic          act_on;
    logic [1:0]    act_dir, new_dir;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          rep_hit;

    // After the first repeat the counter folds back to the delay value, so
    // every later repeat lands REPEAT_RATE ticks apart without a modulo.
    always_comb begin
        new_dir = 2'd0;
        for (int i = 3; i >= 0; i--) if (press[i]) new_dir = 2'(i);
        rep_nxt = rep_cnt + RW'(1);
        rep_hit = act_on && held[act_dir] && (press[3:0] == 4'd0) &&
                  ((rep_nxt == R_DELAY) || (rep_nxt == R_WRAP));
        dir_ev  = press[3:0];
        if (rep_hit) dir_ev[act_dir] = 1'b1;
    end

    always_ff @(posedge clock_50) begin
        if (reset) begin
            act_on  <= 1'b0;
            act_dir <= 2'd0;
            rep_cnt <= '0;
        end else if (tick_d) begin
            if (press[3:0] != 4'd0) begin
                act_on  <= 1'b1;
                act_dir <= new_dir;
                rep_cnt <= '0;
            end else if (act_on && held[act_dir]) begin
                rep_cnt <= (rep_nxt == R_WRAP) ? R_DELAY : rep_nxt;
            end else begin
                act_on <= 1'b0;
            end
        end
    end
`else
    assign dir_ev = press[3:0];
`endif

    always_comb begin
        push_code = CMD_NONE;
        if      (dir_ev[BTN_UP])                   push_code = CMD_UP;
        else if (dir_ev[BTN_DOWN])                 push_code = CMD_DOWN;
        else if (dir_ev[BTN_LEFT])                 push_code = CMD_LEFT;
        else if (dir_ev[BTN_RIGHT])                push_code = CMD_RIGHT;
        else if (press[BTN_A] || press[BTN_C])     push_code = CMD_ACTION;
        else if (press[BTN_B])                     push_code = CMD_MODE;
        else if (press[BTN_START])                 push_code = CMD_START;
    end

    assign push = tick_d && (push_code != CMD_NONE);
    assign pop  = !empty && cmd.cmd_ready;

    cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(3)) u_fifo (
        .clk       (clock_50),
        .rst       (reset),
        .push      (push),
        .push_data (push_code),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (cmd.cmd_code)
    );

    assign cmd.cmd_valid = !empty;

    always_ff @(posedge clock_50) begin
        if (reset) overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

endmodule

// File: tb/tb_pad_cmd_queue.sv
// Directed and random frame-level stimulus for pad_cmd_queue, checked
// against a frame-based reference model with an expected-command queue.
module tb_pad_cmd_queue;
  import pad_pkg::*;

  localparam int DEB   = 2;
  localparam int DELAY = 20;
  localparam int RATE  = 6;
  localparam int DEPTH = 4;

  logic        clock_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        vga_vs   = 1'b0;
  logic [11:0] buttons  = '0;
  logic [11:0] held;
  logic        overflow;

  pad_cmd_queue_if cmd();

  pad_cmd_queue #(
    .DEBOUNCE_FRAMES(DEB),
    .REPEAT_DELAY   (DELAY),
    .REPEAT_RATE    (RATE),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .vga_vs   (vga_vs),
    .buttons  (buttons),
    .held     (held),
    .cmd      (cmd),
    .overflow (overflow)
  );

  // clock/reset
  always #10 clock_50 = ~clock_50;

  // reference model state
  logic [11:0] m_held;
  int          m_cnt [12];
  logic        m_vs_q;
  logic        m_ovf;
  cmd_t        pend;
  logic [2:0]  exp_q[$];
  logic [2:0]  got_q[$];
`ifdef PAD_AUTOREPEAT_EN
  int          act;
  int          k;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = '0;
    for (int i = 0; i < 12; i++) m_cnt[i] = 0;
    m_vs_q = 1'b0;
    m_ovf  = 1'b0;
    pend   = CMD_NONE;
    exp_q.delete();
`ifdef PAD_AUTOREPEAT_EN
    act = -1;
    k   = 0;
`endif
  endtask

  // One frame of the specification: debounce, press detection, repeat, priority.
  task automatic model_frame(input logic [11:0] b);
    logic [11:0] old;
    logic [11:0] pr;
    logic [3:0]  dir;
`ifdef PAD_AUTOREPEAT_EN
    int hi;
`endif
    old = m_held;
    for (int i = 0; i < 12; i++) begin
      if (b[i] !== m_held[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEB) begin
          m_held[i] = ~m_held[i];
          m_cnt[i]  = 0;
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
    pr  = m_held & ~old;
    dir = pr[3:0];
`ifdef PAD_AUTOREPEAT_EN
    hi = -1;
    for (int i = 3; i >= 0; i--) if (pr[i]) hi = i;
    if (hi >= 0) begin
      act = hi;
      k   = 0;
    end else if (act >= 0 && m_held[act]) begin
      k++;
      if (k == DELAY || (k > DELAY && (k - DELAY) % RATE == 0)) dir[act] = 1'b1;
    end else begin
      act = -1;
    end
`endif
    if      (dir[0])          pend = CMD_UP;
    else if (dir[1])          pend = CMD_DOWN;
    else if (dir[2])          pend = CMD_LEFT;
    else if (dir[3])          pend = CMD_RIGHT;
    else if (pr[6] || pr[5])  pend = CMD_ACTION;
    else if (pr[4])           pend = CMD_MODE;
    else if (pr[7])           pend = CMD_START;
    else                      pend = CMD_NONE;
  endtask

  // Effect of one clock edge: pop, then the command decided last cycle, then a new frame.
  task automatic model_edge(input logic vs, input logic rdy);
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    if (pend != CMD_NONE) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pend);
      else m_ovf = 1'b1;
    end
    pend = CMD_NONE;
    if (m_vs_q && !vs) model_frame(buttons);
    m_vs_q = vs;
  endtask

  task automatic check_outputs();
    chk("held", held, m_held);
    chk("cmd_valid", 12'(cmd.cmd_valid), 12'(exp_q.size() > 0));
    chk("cmd_code", 12'(cmd.cmd_code), (exp_q.size() > 0) ? 12'(exp_q[0]) : 12'd0);
    chk("overflow", 12'(overflow), 12'(m_ovf));
  endtask

  // driver tasks
  task automatic do_cycle(input logic vs, input logic rdy);
    @(negedge clock_50);
    vga_vs        = vs;
    cmd.cmd_ready = rdy;
    if (cmd.cmd_valid && rdy) got_q.push_back(cmd.cmd_code);
    @(posedge clock_50);
    model_edge(vs, rdy);
    #1;
    check_outputs();
  endtask

  // rmode: 0 never ready, 1 always ready, 2 random, 3 ready only in the push cycle
  task automatic frame(input logic [11:0] b, input int rmode);
    logic rdy;
    buttons = b;
    for (int c = 0; c < 8; c++) begin
      case (rmode)
        1:       rdy = 1'b1;
        2:       rdy = 1'($urandom_range(0, 1));
        3:       rdy = (c == 4);
        default: rdy = 1'b0;
      endcase
      do_cycle(c < 3, rdy);
    end
  endtask

  task automatic frames(input logic [11:0] b, input int n, input int rmode);
    for (int f = 0; f < n; f++) frame(b, rmode);
  endtask

  task automatic pulse_reset();
    @(negedge clock_50);
    reset = 1'b1;
    @(posedge clock_50);
    model_reset();
    #1;
    chk("rst_valid", 12'(cmd.cmd_valid), 12'd0);
    chk("rst_code", 12'(cmd.cmd_code), 12'd0);
    chk("rst_overflow", 12'(overflow), 12'd0);
    chk("rst_held", held, 12'd0);
    @(negedge clock_50);
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] rb;
    cmd.cmd_ready = 1'b0;
    model_reset();
    pulse_reset();

    // up held five frames: one UP only
    got_q.delete();
    frames(12'h001, 5, 1);
    frames(12'h000, 4, 1);
    chk("up_count", 12'(got_q.size()), 12'd1);
    chk("up_code", (got_q.size() > 0) ? 12'(got_q[0]) : 12'd0, 12'(CMD_UP));

    // one-frame glitch on up
    got_q.delete();
    frame(12'h001, 1);
    frames(12'h000, 4, 1);
    chk("glitch_count", 12'(got_q.size()), 12'd0);

    // left held 40 frames
    got_q.delete();
    frames(12'h004, 40, 1);
    frames(12'h000, 4, 1);
`ifdef PAD_AUTOREPEAT_EN
    chk("left_count", 12'(got_q.size()), 12'd5);
`else
    chk("left_count", 12'(got_q.size()), 12'd1);
`endif

    // up and A in the same frame
    got_q.delete();
    frames(12'h041, 3, 1);
    frames(12'h000, 4, 1);
    chk("upA_count", 12'(got_q.size()), 12'd1);
    chk("upA_code", (got_q.size() > 0) ? 12'(got_q[0]) : 12'd0, 12'(CMD_UP));

    // fill the FIFO with ready low, overflow on the fifth
    frames(12'h001, 2, 0);
    frames(12'h002, 2, 0);
    frames(12'h004, 2, 0);
    frames(12'h008, 2, 0);
    frames(12'h010, 2, 0);
    chk("ovf_set", 12'(overflow), 12'd1);
    // simultaneous pop and push while full
    frame(12'h040, 0);
    frame(12'h040, 3);
    chk("ovf_kept", 12'(overflow), 12'd1);
    got_q.delete();
    frames(12'h000, 4, 1);
    chk("drain_count", 12'(got_q.size()), 12'd4);
    chk("drain_last", (got_q.size() == 4) ? 12'(got_q[3]) : 12'd0, 12'(CMD_ACTION));

    // reset with three entries queued
    frames(12'h001, 2, 0);
    frames(12'h002, 2, 0);
    frames(12'h004, 2, 0);
    pulse_reset();
    frames(12'h000, 3, 1);

    // random buttons and random ready
    rb = '0;
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 2) == 0) rb[$urandom_range(0, 11)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) rb = '0;
      frame(rb, 2);
    end
    frames(12'h000, 6, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
